// File: rtl/prra_grant_ctrl_if.sv
// Grant-control bus between the requesters/NoC input ports and the arbiter back end.
// master = requester side (drives request/done), slave = arbiter side (drives grant outputs).
interface prra_grant_ctrl_if #(
    parameter int WIDTH      = 4,
    parameter int LOG2_WIDTH = 2
);
    // Level handshake: a requester holds request[i] high for as long as it wants the
    // resource; the arbiter answers with a registered one-hot grant that stays put until
    // the owner pulses done or drops its request. grant_valid is always |grant.
    logic [WIDTH-1:0]      request;
    logic                  done;
    logic [WIDTH-1:0]      grant;
    logic [LOG2_WIDTH-1:0] grant_idx;
    logic                  grant_valid;

    modport master (
        output request,
        output done,
        input  grant,
        input  grant_idx,
        input  grant_valid
    );

    modport slave (
        input  request,
        input  done,
        output grant,
        output grant_idx,
        output grant_valid
    );
endinterface

// File: rtl/prra_grant_ctrl.sv
// Pseudo-round-robin grant controller: rotating priority from state+STATE_OFFSET, held one-hot grant.
// Optional macro PRRA_GRANT_CTRL_BACK2BACK_EN re-arbitrates on release with no idle bubble.
module prra_grant_ctrl #(
    parameter int WIDTH        = 4,
    parameter int LOG2_WIDTH   = 2,
    parameter int STATE_OFFSET = 1
) (
    input  logic              clk,
    input  logic              rst,
    prra_grant_ctrl_if.slave  bus,
    output logic              dbg_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fsm_t;

    fsm_t                  cur, nxt;
    logic [WIDTH-1:0]      grant_q, grant_n;
    logic [LOG2_WIDTH-1:0] state_q, state_n;
    logic                  release_now;
    logic [LOG2_WIDTH:0]   idle_pick;

    // Returns {found, index}. Scanning from the far end downward lets the nearest
    // requester (smallest rotation distance) overwrite, so it wins. Modulo WIDTH keeps
    // non-power-of-2 widths wrapping correctly.
    function automatic logic [LOG2_WIDTH:0] pick(input logic [WIDTH-1:0]      req,
                                                 input logic [LOG2_WIDTH-1:0] base);
        logic [LOG2_WIDTH:0] r;
        int                  idx;
        r = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            idx = (int'(base) + STATE_OFFSET + i) % WIDTH;
            if (req[idx]) r = {1'b1, LOG2_WIDTH'(idx)};
        end
        return r;
    endfunction

    assign idle_pick   = pick(bus.request, state_q);
    assign release_now = bus.done || !bus.request[state_q];

`ifdef PRRA_GRANT_CTRL_BACK2BACK_EN
    logic [LOG2_WIDTH:0] b2b_pick;
    assign b2b_pick = pick(bus.request & ~(WIDTH'(1) << state_q), state_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= IDLE;
            grant_q <= '0;
            state_q <= LOG2_WIDTH'(WIDTH - 1);
        end else begin
            cur     <= nxt;
            grant_q <= grant_n;
            state_q <= state_n;
        end
    end

    always_comb begin
        nxt     = cur;
        grant_n = grant_q;
        state_n = state_q;
        case (cur)
            IDLE: begin
                // done is meaningless without an owner, so it is not looked at here
                if (idle_pick[LOG2_WIDTH]) begin
                    nxt     = BUSY;
                    state_n = idle_pick[LOG2_WIDTH-1:0];
                    grant_n = WIDTH'(1) << idle_pick[LOG2_WIDTH-1:0];
                end
            end
            BUSY: begin
                if (release_now) begin
`ifdef PRRA_GRANT_CTRL_BACK2BACK_EN
                    if (b2b_pick[LOG2_WIDTH]) begin
                        state_n = b2b_pick[LOG2_WIDTH-1:0];
                        grant_n = WIDTH'(1) << b2b_pick[LOG2_WIDTH-1:0];
                    end else begin
                        nxt     = IDLE;
                        grant_n = '0;
                    end
`else
                    nxt     = IDLE;
                    grant_n = '0;
`endif
                end
            end
            default: begin
                nxt     = IDLE;
                grant_n = '0;
            end
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = state_q;
    assign bus.grant_valid = |grant_q;
    assign dbg_busy        = (cur == BUSY);

endmodule
